mez_bus_ctrl: RTL and testbench
===============================

MEZ_BUS_CTRL -- requirements
Module: mez_bus_ctrl

Interface
REQ-001 SHALL have parameter: NCH, 4, number of decode channels.
REQ-002 SHALL have parameter: SELW, 7, width of addrSel.
REQ-003 SHALL have parameter: WSW, 4, per-channel wait-state count width.
REQ-004 SHALL have parameter: TMO, 255, unclaimed-cycle bus-timeout limit in sysClk cycles.
REQ-005 SHALL have port: sysClk  in  1  primary system clock, rising edge.
REQ-006 SHALL have port: nReset  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: nAS, nDS, RnW, addr31  in  1 each  CPU address strobe, data strobe, read/write, address bit 31.
REQ-008 SHALL have port: cpuFC  in  2  CPU function code bits.
REQ-009 SHALL have port: addrSel  in  SELW  address select bits.
REQ-010 SHALL have port: chSel  in  NCH*SELW  per-channel addrSel match value.
REQ-011 SHALL have port: chCpuSp  in  NCH  1 = channel in CPU space.
REQ-012 SHALL have port: chWait  in  NCH*WSW  per-channel wait states.
REQ-013 SHALL have port: chWidth  in  NCH*2  port width (00=32, 01=16, 10=8, 11=invalid).
REQ-014 SHALL have port: nChSense  in  NCH  device present, active-low.
REQ-015 SHALL have port: nChCE  out  NCH  channel enables, active-low.
REQ-016 SHALL have ports: nRdStb, nWrStb  out  1 each  device read/write strobes, active-low.
REQ-017 SHALL have port: znDsack  inout  2  open-drain DSACK[1:0].
REQ-018 SHALL have port: znBerr  inout  1  open-drain bus error.

Function
REQ-019 Channel i SHALL match when addrSel==chSel[i] and, if chCpuSp[i], cpuFC==11; else cpuFC!=11 and addr31==1.
REQ-020 Multiple matches SHALL resolve to the lowest index.
REQ-021 nChCE SHALL be combinational from the decode, not gated by nAS or the clock, so that it asserts before nAS falls.
REQ-022 FSM states SHALL be: IDLE, WAIT, ACK, BERR, WATCH.
REQ-023 IDLE transitions on a posedge with nAS low:
- matched channel present -> WAIT, counter=chWait[ch], channel index latched;
- matched channel absent (nChSense high) or chWidth==11 -> BERR;
- no match -> WATCH, timeout counter=0.
REQ-024 WAIT: each edge, counter==0 -> ACK, else counter decrements; for nAS sampled low at edge N, ACK is entered at edge N+1+chWait.
REQ-025 ACK SHALL drive znDsack: width 00 -> 00, width 01 -> 01, width 10 -> 10 (0 = driven low); held until nAS is sampled high, then IDLE.
REQ-026 BERR SHALL drive znBerr low until nAS is sampled high, then IDLE.
REQ-027 WATCH SHALL increment the timeout counter each edge; counter==TMO -> BERR; nAS high -> IDLE.
REQ-028 nAS sampled high in WAIT SHALL return to IDLE with nothing driven.
REQ-029 znDsack and znBerr SHALL be Z in all states other than ACK and BERR respectively, and never driven high.
REQ-030 Strobes SHALL be registered: asserted in WAIT and ACK when nDS is sampled low and RnW selects the direction (1 = nRdStb); negated the edge after nDS is sampled high or on any state exit.
REQ-031 Config and nChSense changes after latching SHALL NOT affect the current cycle.
REQ-032 Counters SHALL saturate, never wrap; TMO SHALL fit in an 8-bit counter or the counter SHALL be sized $clog2(TMO+1).

Reset
REQ-033 On nReset low: state IDLE, counters 0, znDsack=ZZ, znBerr=Z, nRdStb=nWrStb=1; nChCE stays combinational.
REQ-034 Reset asserted mid-cycle SHALL release all drivers immediately, asynchronously.

Structure
REQ-035 Package mez_bus_pkg SHALL hold the state enum and the width codes W32, W16, W8, WINV.
REQ-036 Sub-module mez_decode SHALL hold the combinational priority decoder, outputting match, index and one-hot nChCE.

Verification
REQ-037 Ch0 chSel=0010001, chCpuSp=1, present, width 00, wait 0; FC=11 access -> nChCE[0] low before nAS falls; znDsack=00 at edge N+1.
REQ-038 Ch1 wait 3, width 01, read -> znDsack=01 at edge N+4; nRdStb low during WAIT/ACK; all released the edge after nAS is sampled high.
REQ-039 Ch0 access with nChSense[0] high -> znBerr low the edge after nAS is sampled low; no DSACK; nChCE[0] still asserted.
REQ-040 Unmatched address, nAS held low -> znBerr low at edge N+1+TMO; nAS is negated at edge N+10 -> no BERR.
REQ-041 Ch0 and ch2 both match -> only nChCE[0] low, ch0 timing; chWidth=11 -> BERR.
REQ-042 nReset pulsed during WAIT, or nAS negated in WAIT -> IDLE, drivers Z, no DSACK.

Source files
------------

// File: rtl/mez_bus_pkg.sv
// Shared types and encodings for the mezzanine bus controller.
package mez_bus_pkg;

    // Bus-cycle controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        ACK   = 3'd2,
        BERR  = 3'd3,
        WATCH = 3'd4
    } mezState_t;

    // Port-width codes as programmed in chWidth
    localparam logic [1:0] W32  = 2'b00;
    localparam logic [1:0] W16  = 2'b01;
    localparam logic [1:0] W8   = 2'b10;
    localparam logic [1:0] WINV = 2'b11;

    // Which DSACK lines to pull low for a given port width (1 = pull low)
    function automatic logic [1:0] dsackPull(input logic [1:0] widthCode);
        logic [1:0] pull;
        case (widthCode)
            W32:     pull = 2'b11;
            W16:     pull = 2'b10;
            W8:      pull = 2'b01;
            default: pull = 2'b00;
        endcase
        return pull;
    endfunction

endpackage

// File: rtl/mez_decode.sv
// Combinational channel decoder: address/space compare with lowest-index priority.
module mez_decode
    import mez_bus_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = 7,
    parameter int IDXW = 2
) (
    input  logic [1:0]          cpuFC,
    input  logic                addr31,
    input  logic [SELW-1:0]     addrSel,
    input  logic [NCH*SELW-1:0] chSel,
    input  logic [NCH-1:0]      chCpuSp,
    output logic                match,
    output logic [IDXW-1:0]     index,
    output logic [NCH-1:0]      nChCE
);

    logic [NCH-1:0] hit_s;
    logic           cpuSpace_s;

    assign cpuSpace_s = (cpuFC == 2'b11);

    // Per-channel compare of select bits and address space
    always_comb begin
        hit_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (addrSel != chSel[i*SELW +: SELW]) begin
                hit_s[i] = 1'b0;
            end else if (chCpuSp[i]) begin
                hit_s[i] = cpuSpace_s;
            end else begin
                hit_s[i] = !cpuSpace_s && addr31;
            end
        end
    end

    // Lowest-index hit wins; only the winner's enable goes low
    always_comb begin
        match = 1'b0;
        index = {IDXW{1'b0}};
        nChCE = {NCH{1'b1}};
        for (int i = 0; i < NCH; i++) begin
            if (hit_s[i] && !match) begin
                match    = 1'b1;
                index    = IDXW'(i);
                nChCE[i] = 1'b0;
            end else begin
                nChCE[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mez_bus_ctrl.sv
// Mezzanine bus controller: decodes CPU cycles to channels, inserts wait
// states, returns DSACK/BERR on open-drain lines and drives device strobes.
module mez_bus_ctrl
    import mez_bus_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = 7,
    parameter int WSW  = 4,
    parameter int TMO  = 255
) (
    input  logic                sysClk,
    input  logic                nReset,
    input  logic                nAS,
    input  logic                nDS,
    input  logic                RnW,
    input  logic                addr31,
    input  logic [1:0]          cpuFC,
    input  logic [SELW-1:0]     addrSel,
    input  logic [NCH*SELW-1:0] chSel,
    input  logic [NCH-1:0]      chCpuSp,
    input  logic [NCH*WSW-1:0]  chWait,
    input  logic [NCH*2-1:0]    chWidth,
    input  logic [NCH-1:0]      nChSense,
    output logic [NCH-1:0]      nChCE,
    output logic                nRdStb,
    output logic                nWrStb,
    inout  wire  [1:0]          znDsack,
    inout  wire                 znBerr
);

    localparam int             IDXW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int             TCW       = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [TCW-1:0] TMO_LIMIT = TCW'(TMO);
    localparam logic [TCW-1:0] TMO_ONE   = TCW'(1);
    localparam logic [WSW-1:0] WAIT_ONE  = WSW'(1);

    mezState_t       state_r;
    mezState_t       next_s;
    logic [WSW-1:0]  waitCnt_r;
    logic [TCW-1:0]  tmoCnt_r;
    logic [1:0]      width_r;
    logic [1:0]      dsackDrv_r;
    logic            berrDrv_r;
    logic            nRdStb_r;
    logic            nWrStb_r;

    logic            match_s;
    logic [IDXW-1:0] idx_s;
    logic [1:0]      selWidth_s;
    logic [WSW-1:0]  selWait_s;
    logic            selAbsent_s;
    logic            inCycle_s;

    mez_decode #(
        .NCH  (NCH),
        .SELW (SELW),
        .IDXW (IDXW)
    ) uDecode (
        .cpuFC   (cpuFC),
        .addr31  (addr31),
        .addrSel (addrSel),
        .chSel   (chSel),
        .chCpuSp (chCpuSp),
        .match   (match_s),
        .index   (idx_s),
        .nChCE   (nChCE)
    );

    assign selWidth_s  = chWidth[int'(idx_s) * 2 +: 2];
    assign selWait_s   = chWait[int'(idx_s) * WSW +: WSW];
    assign selAbsent_s = nChSense[idx_s];

    // Claimed cycle continues across this edge (strobes may stay asserted)
    assign inCycle_s = ((state_r == WAIT) || (state_r == ACK)) &&
                       ((next_s == WAIT) || (next_s == ACK));

    // Next-state decision; nAS negation always wins over counter expiry
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (nAS) begin
                    next_s = IDLE;
                end else if (!match_s) begin
                    next_s = WATCH;
                end else if (selAbsent_s || (selWidth_s == WINV)) begin
                    next_s = BERR;
                end else begin
                    next_s = WAIT;
                end
            end
            WAIT: begin
                if (nAS) begin
                    next_s = IDLE;
                end else if (waitCnt_r == {WSW{1'b0}}) begin
                    next_s = ACK;
                end else begin
                    next_s = WAIT;
                end
            end
            ACK: begin
                if (nAS) begin
                    next_s = IDLE;
                end else begin
                    next_s = ACK;
                end
            end
            BERR: begin
                if (nAS) begin
                    next_s = IDLE;
                end else begin
                    next_s = BERR;
                end
            end
            WATCH: begin
                if (nAS) begin
                    next_s = IDLE;
                end else if (tmoCnt_r == TMO_LIMIT) begin
                    next_s = BERR;
                end else begin
                    next_s = WATCH;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Wait/timeout counters and width latch; channel attributes frozen at claim
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            waitCnt_r <= {WSW{1'b0}};
            tmoCnt_r  <= {TCW{1'b0}};
            width_r   <= W32;
        end else begin
            case (state_r)
                IDLE: begin
                    tmoCnt_r <= {TCW{1'b0}};
                    if (next_s == WAIT) begin
                        waitCnt_r <= selWait_s;
                        width_r   <= selWidth_s;
                    end else begin
                        waitCnt_r <= {WSW{1'b0}};
                    end
                end
                WAIT: begin
                    if (waitCnt_r != {WSW{1'b0}}) begin
                        waitCnt_r <= waitCnt_r - WAIT_ONE;
                    end
                end
                WATCH: begin
                    if (tmoCnt_r != TMO_LIMIT) begin
                        tmoCnt_r <= tmoCnt_r + TMO_ONE;
                    end
                end
                default: begin
                    tmoCnt_r <= tmoCnt_r;
                end
            endcase
        end
    end

    // Open-drain pull-down enables, registered from the next state
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            dsackDrv_r <= 2'b00;
            berrDrv_r  <= 1'b0;
        end else begin
            dsackDrv_r <= (next_s == ACK) ? dsackPull(width_r) : 2'b00;
            berrDrv_r  <= (next_s == BERR);
        end
    end

    // Device strobes follow nDS/RnW only while a claimed cycle continues
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            nRdStb_r <= 1'b1;
            nWrStb_r <= 1'b1;
        end else begin
            nRdStb_r <= !(inCycle_s && !nDS && RnW);
            nWrStb_r <= !(inCycle_s && !nDS && !RnW);
        end
    end

    assign nRdStb     = nRdStb_r;
    assign nWrStb     = nWrStb_r;
    assign znDsack[0] = dsackDrv_r[0] ? 1'b0 : 1'bz;
    assign znDsack[1] = dsackDrv_r[1] ? 1'b0 : 1'bz;
    assign znBerr     = berrDrv_r     ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_mez_bus_ctrl.sv
// Bench for mez_bus_ctrl: bus-cycle-level model plus directed scenarios.
module tb_mez_bus_ctrl;

    localparam int NCH  = 4;
    localparam int SELW = 7;
    localparam int WSW  = 4;
    localparam int TMO  = 255;
    localparam int K_ACK  = 0;
    localparam int K_BERR = 1;
    localparam int K_TMO  = 2;

    logic                sysClk  = 1'b0;
    logic                nReset  = 1'b0;
    logic                nAS     = 1'b1;
    logic                nDS     = 1'b1;
    logic                RnW     = 1'b1;
    logic                addr31  = 1'b0;
    logic [1:0]          cpuFC   = 2'b00;
    logic [SELW-1:0]     addrSel = 7'h00;
    logic [NCH*SELW-1:0] chSel;
    logic [NCH-1:0]      chCpuSp;
    logic [NCH*WSW-1:0]  chWait;
    logic [NCH*2-1:0]    chWidth;
    logic [NCH-1:0]      nChSense;
    wire  [NCH-1:0]      nChCE;
    wire                 nRdStb;
    wire                 nWrStb;
    wire  [1:0]          znDsack;
    wire                 znBerr;

    pullup pu0 (znDsack[0]);
    pullup pu1 (znDsack[1]);
    pullup pu2 (znBerr);

    int checks = 0;
    int errors = 0;

    mez_bus_ctrl #(.NCH(NCH), .SELW(SELW), .WSW(WSW), .TMO(TMO)) dut (
        .sysClk   (sysClk),
        .nReset   (nReset),
        .nAS      (nAS),
        .nDS      (nDS),
        .RnW      (RnW),
        .addr31   (addr31),
        .cpuFC    (cpuFC),
        .addrSel  (addrSel),
        .chSel    (chSel),
        .chCpuSp  (chCpuSp),
        .chWait   (chWait),
        .chWidth  (chWidth),
        .nChSense (nChSense),
        .nChCE    (nChCE),
        .nRdStb   (nRdStb),
        .nWrStb   (nWrStb),
        .znDsack  (znDsack),
        .znBerr   (znBerr)
    );

    always #5 sysClk = ~sysClk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysClk);
            #2;
        end
    endtask

    // First channel (lowest index) satisfying the address and space rules, -1 if none
    function automatic int firstMatch(input logic [SELW-1:0] sel, input logic [1:0] fc,
                                      input logic a31, input logic [NCH*SELW-1:0] cs,
                                      input logic [NCH-1:0] sp);
        logic spaceOk;
        for (int i = 0; i < NCH; i++) begin
            spaceOk = sp[i] ? (fc == 2'b11) : ((fc != 2'b11) && a31);
            if ((sel == cs[i*SELW +: SELW]) && spaceOk) return i;
        end
        return -1;
    endfunction

    int curCh;
    always_comb curCh = firstMatch(addrSel, cpuFC, addr31, chSel, chCpuSp);

    // Cycle-level model: which access is in progress, when it began, and its outcome
    int         edgeCnt = 0;
    int         mStart  = 0;
    int         mWait   = 0;
    int         mKind   = 0;
    logic       mBusy   = 1'b0;
    logic       mRd     = 1'b0;
    logic       mWr     = 1'b0;
    logic [1:0] mWidth  = 2'b00;

    always @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            mBusy <= 1'b0;
            mRd   <= 1'b0;
            mWr   <= 1'b0;
        end else begin
            edgeCnt <= edgeCnt + 1;
            if (nAS) begin
                mBusy <= 1'b0;
                mRd   <= 1'b0;
                mWr   <= 1'b0;
            end else if (!mBusy) begin
                mBusy  <= 1'b1;
                mStart <= edgeCnt + 1;
                mRd    <= 1'b0;
                mWr    <= 1'b0;
                if (curCh < 0) begin
                    mKind <= K_TMO;
                end else if (nChSense[curCh] || (chWidth[curCh*2 +: 2] == 2'b11)) begin
                    mKind <= K_BERR;
                end else begin
                    mKind  <= K_ACK;
                    mWait  <= int'(chWait[curCh*WSW +: WSW]);
                    mWidth <= chWidth[curCh*2 +: 2];
                end
            end else begin
                mRd <= (mKind == K_ACK) && !nDS && RnW;
                mWr <= (mKind == K_ACK) && !nDS && !RnW;
            end
        end
    end

    // Compare every output against the model midway between rising edges
    initial begin
        logic [NCH-1:0] eCE;
        logic [1:0]     eDs;
        logic           eBerr;
        forever begin
            @(negedge sysClk);
            eCE = {NCH{1'b1}};
            if (curCh >= 0) eCE[curCh] = 1'b0;
            eDs   = 2'b11;
            eBerr = 1'b1;
            if (mBusy && (mKind == K_ACK) && (edgeCnt >= mStart + 1 + mWait)) eDs = mWidth;
            if (mBusy && ((mKind == K_BERR) ||
                          ((mKind == K_TMO) && (edgeCnt >= mStart + 1 + TMO)))) eBerr = 1'b0;
            check("cmpCE",    nChCE,   eCE);
            check("cmpDsack", znDsack, eDs);
            check("cmpBerr",  znBerr,  eBerr);
            check("cmpRd",    nRdStb,  !mRd);
            check("cmpWr",    nWrStb,  !mWr);
        end
    end

    initial begin
        chSel    = {7'h33, 7'b0010001, 7'h22, 7'b0010001};
        chCpuSp  = 4'b0101;
        chWait   = {4'd1, 4'd2, 4'd3, 4'd0};
        chWidth  = {2'b11, 2'b10, 2'b01, 2'b00};
        nChSense = 4'b0000;
        tick(2);
        check("rstDsack", znDsack, 2'b11);
        check("rstBerr",  znBerr,  1'b1);
        check("rstRd",    nRdStb,  1'b1);
        check("rstWr",    nWrStb,  1'b1);
        nReset = 1'b1;
        tick(2);

        // ch0 (CPU space) write, zero wait, ch2 also matches but loses
        cpuFC = 2'b11; addr31 = 1'b0; addrSel = 7'b0010001; RnW = 1'b0;
        #1 check("ceBeforeAs", nChCE, 4'b1110);
        nAS = 1'b0; nDS = 1'b0;
        tick(1);
        check("ch0DsWait", znDsack, 2'b11);
        tick(1);
        check("ch0Dsack", znDsack, 2'b00);
        check("ch0WrStb", nWrStb, 1'b0);
        nAS = 1'b1; nDS = 1'b1;
        tick(1);
        check("ch0Rel", znDsack, 2'b11);
        check("ch0WrRel", nWrStb, 1'b1);
        tick(1);

        // ch1 read, 3 waits, 16-bit; config disturbed after claim
        cpuFC = 2'b01; addr31 = 1'b1; addrSel = 7'h22; RnW = 1'b1;
        nAS = 1'b0; nDS = 1'b0;
        tick(2);
        check("ch1RdStb", nRdStb, 1'b0);
        chWidth[3:2] = 2'b10; nChSense[1] = 1'b1; chWait[7:4] = 4'd9;
        tick(2);
        check("ch1DsN3", znDsack, 2'b11);
        tick(1);
        check("ch1DsN4", znDsack, 2'b01);
        chWidth[3:2] = 2'b01; nChSense[1] = 1'b0; chWait[7:4] = 4'd3;
        nAS = 1'b1; nDS = 1'b1;
        tick(1);
        check("ch1Rel", znDsack, 2'b11);
        check("ch1RdRel", nRdStb, 1'b1);
        tick(1);

        // ch0 absent
        nChSense = 4'b0001;
        cpuFC = 2'b11; addr31 = 1'b0; addrSel = 7'b0010001;
        nAS = 1'b0;
        tick(1);
        check("absBerr", znBerr, 1'b0);
        check("absCE", nChCE, 4'b1110);
        tick(2);
        nAS = 1'b1;
        tick(1);
        check("absRel", znBerr, 1'b1);
        nChSense = 4'b0000;
        tick(1);

        // ch3 invalid width
        cpuFC = 2'b10; addr31 = 1'b1; addrSel = 7'h33;
        nAS = 1'b0;
        tick(1);
        check("winvBerr", znBerr, 1'b0);
        nAS = 1'b1;
        tick(2);

        // unmatched, negated before timeout
        cpuFC = 2'b01; addr31 = 1'b1; addrSel = 7'h7F;
        nAS = 1'b0;
        tick(10);
        nAS = 1'b1;
        tick(1);
        check("tmoShort", znBerr, 1'b1);
        tick(1);

        // unmatched, held to timeout
        nAS = 1'b0;
        tick(1 + TMO);
        check("tmoBefore", znBerr, 1'b1);
        tick(1);
        check("tmoBerr", znBerr, 1'b0);
        nAS = 1'b1;
        tick(1);
        check("tmoRel", znBerr, 1'b1);
        tick(1);

        // reset pulse during ch1 wait states
        cpuFC = 2'b01; addr31 = 1'b1; addrSel = 7'h22; RnW = 1'b1;
        nAS = 1'b0; nDS = 1'b0;
        tick(2);
        #1 nReset = 1'b0;
        #1 check("rstMidRd", nRdStb, 1'b1);
        nAS = 1'b1; nDS = 1'b1;
        tick(1);
        check("rstMidDs", znDsack, 2'b11);
        nReset = 1'b1;
        tick(5);
        check("rstAfterDs", znDsack, 2'b11);

        // nAS negated during wait states
        nAS = 1'b0; nDS = 1'b0;
        tick(2);
        nAS = 1'b1; nDS = 1'b1;
        tick(5);
        check("abortDs", znDsack, 2'b11);
        check("abortRd", nRdStb, 1'b1);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
